// File: rtl/fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_sequencer : owns the PC, fetches from imem, hands instructions to decode
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        align_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_VALID  = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drain_addr_q, drain_addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        halt_pend_q, halt_pend_d;

  logic [15:0] redir_tgt;
  logic        halt_now;

  assign redir_tgt = redirect_pc & 16'hFFFE;
  assign halt_now  = halt | halt_pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= NOP_INSTR;
      ifpc_q       <= RESET_PC;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    valid_d      = valid_q;
    halt_pend_d  = 1'b0;
    err_d        = err_q | (redirect_valid & redirect_pc[0] & (state_q != S_HALTED));

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redir_tgt;
        state_d = halt ? S_HALTED : S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) pc_d = redir_tgt;
          if (halt_now) begin
            state_d = S_HALTED;
          end else if (redirect_valid) begin
            state_d = S_FETCH;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 16'd2;
            state_d = S_VALID;
          end
        end else begin
          halt_pend_d = halt_now;
          // The old address must stay on the bus until its ack arrives.
          if (redirect_valid) begin
            pc_d         = redir_tgt;
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_d = redir_tgt;
        if (imem_ack) begin
          state_d = halt_now ? S_HALTED : S_FETCH;
        end else begin
          halt_pend_d = halt_now;
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          valid_d = 1'b0;
          state_d = halt ? S_HALTED : S_FETCH;
        end else if (halt) begin
          valid_d = 1'b0;
          state_d = S_HALTED;
        end else if (if_ready) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = valid_q ? instr_q : NOP_INSTR;
  assign if_pc       = ifpc_q;
  assign if_pc_plus2 = ifpc_q + 16'd2;
  assign halted      = (state_q == S_HALTED);
  assign align_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : directed + random stimulus against a transaction model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        align_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: a request in flight, an instruction held for decode, or neither.
  logic        m_busy, m_drop, m_halting, m_halted, m_hold, m_err;
  logic [15:0] m_pc, m_raddr, m_hinstr, m_hpc;

  fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_drop = 1'b0; m_halting = 1'b0; m_halted = 1'b0;
    m_hold = 1'b0; m_err = 1'b0;
    m_pc = RESET_PC; m_raddr = RESET_PC; m_hinstr = NOP; m_hpc = RESET_PC;
  endtask

  task automatic model_tick();
    if (!m_halted) begin
      if (redirect_valid) begin
        m_pc  = {redirect_pc[15:1], 1'b0};
        m_err = m_err | redirect_pc[0];
      end
      if (m_busy) begin
        if (redirect_valid) m_drop = 1'b1;
        if (halt) m_halting = 1'b1;
        if (imem_ack) begin
          if (m_halting) begin
            m_busy = 1'b0; m_halted = 1'b1;
          end else if (m_drop) begin
            m_raddr = m_pc;
          end else begin
            m_busy = 1'b0; m_hold = 1'b1;
            m_hinstr = imem_rdata; m_hpc = m_raddr; m_pc = m_raddr + 16'd2;
          end
          m_drop = 1'b0; m_halting = 1'b0;
        end
      end else if (m_hold) begin
        if (redirect_valid || halt || if_ready) begin
          m_hold = 1'b0;
          if (halt) m_halted = 1'b1;
          else begin m_busy = 1'b1; m_raddr = m_pc; end
        end
      end else begin
        if (halt) m_halted = 1'b1;
        else begin m_busy = 1'b1; m_raddr = m_pc; end
      end
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {15'd0, imem_req}, {15'd0, m_busy});
    if (m_busy) chk("imem_addr", imem_addr, m_raddr);
    chk("if_valid", {15'd0, if_valid}, {15'd0, m_hold});
    chk("if_instr", if_instr, m_hold ? m_hinstr : NOP);
    chk("if_pc", if_pc, m_hpc);
    chk("if_pc_plus2", if_pc_plus2, m_hpc + 16'd2);
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    chk("align_err", {15'd0, align_err}, {15'd0, m_err});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic a, input logic [15:0] d, input logic rdy,
                      input logic rv, input logic [15:0] rp, input logic h);
    imem_ack = a; imem_rdata = d; if_ready = rdy;
    redirect_valid = rv; redirect_pc = rp; halt = h;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_if_pc_plus2", if_pc_plus2, RESET_PC + 16'd2);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic go_busy();
    for (int i = 0; i < 12 && !m_busy; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("reach_fetch", {15'd0, imem_req}, 16'd1);
  endtask

  initial begin
    rst = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Zero-wait acks with decode always ready: 0000, 0002, 0004 ...
    step(1'b0, 16'h1111, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("first_fetch_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 4; i++) step(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);

    // Three wait cycles on a fetch, then ack.
    go_busy();
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("delayed_ack_data", if_instr, 16'hBEEF);

    // Decode stalls for five cycles, then releases.
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Redirect while a fetch is pending: drain old address, fetch the target.
    go_busy();
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("post_drain_addr", imem_addr, 16'h0040);
    step(1'b1, 16'h4040, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("redirect_instr", if_instr, 16'h4040);

    // Misaligned redirect from VALID, then wrap at 0xFFFE.
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0033, 1'b0);
    chk("misaligned_addr", imem_addr, 16'h0032);
    step(1'b1, 16'h3232, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("wrap_plus2", if_pc_plus2, 16'h0000);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("wrap_fetch_addr", imem_addr, 16'h0000);
    chk("align_sticky", {15'd0, align_err}, 16'd1);

    // Halt during a pending fetch.
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0, 1'b1, 1'b1, 16'h0101, 1'b0);
    chk("halted_no_req", {15'd0, imem_req}, 16'd0);

    // Reset mid-fetch, then a stray ack after release.
    do_reset();
    go_busy();
    do_reset();
    step(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Random episodes.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 499) == 0) do_reset();
        step($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 399) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
